// File: rtl/can_dma_pkg.sv
// Shared field layout, slot layout and FSM encodings for the CAN DMA mover.
// Build option: CAN_DMA_RX_TIMESTAMP_EN adds an RX timestamp word per slot.
package can_dma_pkg;

  localparam int FIELDS_W = 25;

  localparam int F_DLC_LSB   = 0;
  localparam int F_RADDR_LSB = 4;
  localparam int F_MTYPE_BIT = 10;
  localparam int F_HS_LSB    = 11;
  localparam int F_EXP_LSB   = 13;
  localparam int F_CMD_LSB   = 17;

  localparam int SET_VALID_BIT = 31;
  localparam int SET_WRAP_BIT  = 30;

  localparam int SLOT_SET_OFS = 0;
  localparam int SLOT_DAT_OFS = 1;

  typedef struct packed {
    logic [7:0] cmd_data_sign;
    logic [3:0] expand_count;
    logic [1:0] handshake;
    logic       message_type;
    logic [5:0] remote_address;
    logic [3:0] dlc;
  } can_fields_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_RD_SET,
    T_WAIT_SET,
    T_RD_DAT,
    T_WAIT_DAT,
    T_PRESENT,
    T_SENDING
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WR_DAT,
    R_WAIT_DAT,
    R_WR_SET,
    R_WAIT_SET
  } rx_state_t;

  function automatic can_fields_t decode(
    input logic [FIELDS_W-1:0] w
  );
    can_fields_t d;
    d.cmd_data_sign  = w[F_CMD_LSB +: 8];
    d.expand_count   = w[F_EXP_LSB +: 4];
    d.handshake      = w[F_HS_LSB +: 2];
    d.message_type   = w[F_MTYPE_BIT];
    d.remote_address = w[F_RADDR_LSB +: 6];
    d.dlc            = w[F_DLC_LSB +: 4];
    return d;
  endfunction

  function automatic logic [31:0] set_word(
    input logic                wrap,
    input logic [FIELDS_W-1:0] f
  );
    logic [31:0] w;
    w = '0;
    w[SET_VALID_BIT] = 1'b1;
    w[SET_WRAP_BIT]  = wrap;
    w[FIELDS_W-1:0]  = f;
    return w;
  endfunction

endpackage

// File: rtl/can_dma_rx_ring.sv
// RX ring writer: skid buffer, slot write FSM, head pointer, overflow count.
// Build option: CAN_DMA_RX_TIMESTAMP_EN writes a cycle stamp per slot.
module can_dma_rx_ring
  import can_dma_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 20,
  parameter int RX_SLOTS    = 8,
  parameter int SLOT_STRIDE = 4,
  parameter logic [ADDR_WIDTH-1:0] RX_BASE = 20'hB0000,
  localparam int PW = $clog2(RX_SLOTS) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_frame_ready_i,
  input  logic [FIELDS_W-1:0]   rx_fields_i,
  input  logic [63:0]           rx_data_i,
  input  logic [PW-1:0]         rx_tail_i,
  output logic [PW-1:0]         rx_head_o,
  output logic                  rx_stored_o,
  output logic [7:0]            rx_overflow_cnt_o,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic                  wr_en,
  input  logic                  wr_done,
  input  logic                  wr_busy
);

  localparam int IW    = PW - 1;
  localparam int WORDS = 64 / DATA_WIDTH;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
  localparam int NWR = WORDS + 1;
`else
  localparam int NWR = WORDS;
`endif

  rx_state_t             st;
  logic [PW-1:0]         tail_q;
  logic [FIELDS_W-1:0]   cur_fields;
  logic [63:0]           dat_sr;
  logic [63:0]           sr_next;
  logic [1:0]            widx;
  logic                  sk_v;
  logic [FIELDS_W-1:0]   sk_fields;
  logic [63:0]           sk_data;
  logic                  full;
  logic [ADDR_WIDTH-1:0] slot_base;
  logic                  ld_go;
  logic                  ld_skid;
  logic                  to_skid;
  logic                  drop;
  logic [FIELDS_W-1:0]   ld_fields;
  logic [63:0]           ld_data;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
  logic [31:0]           ts_cnt;
  logic [31:0]           cur_ts;
  logic [31:0]           sk_ts;
  logic [31:0]           ld_ts;
`endif

  assign full = (rx_head_o[IW-1:0] == tail_q[IW-1:0]) &&
                (rx_head_o[IW] != tail_q[IW]);
  assign slot_base = RX_BASE +
    ADDR_WIDTH'(rx_head_o[IW-1:0]) * ADDR_WIDTH'(SLOT_STRIDE);
  assign wr_en = (st == R_WR_DAT || st == R_WR_SET) && !wr_busy;
  assign sr_next = dat_sr << DATA_WIDTH;

  // A waiting skid frame has priority; a new arrival then refills the skid.
  always_comb begin
    ld_go   = 1'b0;
    ld_skid = 1'b0;
    to_skid = 1'b0;
    drop    = 1'b0;
    if (st == R_IDLE) begin
      if (sk_v && !full) begin
        ld_go   = 1'b1;
        ld_skid = 1'b1;
        to_skid = rx_frame_ready_i;
      end else if (rx_frame_ready_i) begin
        if (!full) begin
          ld_go = 1'b1;
        end else begin
          drop    = 1'b1;
          to_skid = sk_v;
        end
      end
    end else if (rx_frame_ready_i) begin
      if (sk_v) drop = 1'b1;
      else      to_skid = 1'b1;
    end
  end

  assign ld_fields = ld_skid ? sk_fields : rx_fields_i;
  assign ld_data   = ld_skid ? sk_data   : rx_data_i;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
  assign ld_ts     = ld_skid ? sk_ts     : ts_cnt;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st                <= R_IDLE;
      tail_q            <= '0;
      rx_head_o         <= '0;
      rx_stored_o       <= 1'b0;
      rx_overflow_cnt_o <= '0;
      addr_wr           <= '0;
      data_wr           <= '0;
      cur_fields        <= '0;
      dat_sr            <= '0;
      widx              <= '0;
      sk_v              <= 1'b0;
      sk_fields         <= '0;
      sk_data           <= '0;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
      ts_cnt            <= '0;
      cur_ts            <= '0;
      sk_ts             <= '0;
`endif
    end else begin
      tail_q      <= rx_tail_i;
      rx_stored_o <= 1'b0;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
      ts_cnt      <= ts_cnt + 32'd1;
`endif
      if (to_skid) begin
        sk_v      <= 1'b1;
        sk_fields <= rx_fields_i;
        sk_data   <= rx_data_i;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
        sk_ts     <= ts_cnt;
`endif
      end else if (ld_skid) begin
        sk_v <= 1'b0;
      end
      if (drop && rx_overflow_cnt_o != 8'hFF)
        rx_overflow_cnt_o <= rx_overflow_cnt_o + 8'd1;
      case (st)
        R_IDLE: if (ld_go) begin
          st         <= R_WR_DAT;
          cur_fields <= ld_fields;
          dat_sr     <= ld_data;
          data_wr    <= ld_data[63 -: DATA_WIDTH];
          addr_wr    <= slot_base + ADDR_WIDTH'(SLOT_DAT_OFS);
          widx       <= '0;
`ifdef CAN_DMA_RX_TIMESTAMP_EN
          cur_ts     <= ld_ts;
`endif
        end
        R_WR_DAT: if (!wr_busy) st <= R_WAIT_DAT;
        R_WAIT_DAT: if (wr_done) begin
          if (widx == 2'(NWR - 1)) begin
            st      <= R_WR_SET;
            addr_wr <= slot_base + ADDR_WIDTH'(SLOT_SET_OFS);
            data_wr <= DATA_WIDTH'(
              set_word(rx_head_o[IW], cur_fields));
          end else begin
            st      <= R_WR_DAT;
            widx    <= widx + 2'd1;
            addr_wr <= addr_wr + ADDR_WIDTH'(1);
            dat_sr  <= sr_next;
            data_wr <= sr_next[63 -: DATA_WIDTH];
`ifdef CAN_DMA_RX_TIMESTAMP_EN
            if (widx == 2'(WORDS - 1))
              data_wr <= DATA_WIDTH'(cur_ts);
`endif
          end
        end
        R_WR_SET: if (!wr_busy) st <= R_WAIT_SET;
        R_WAIT_SET: if (wr_done) begin
          st          <= R_IDLE;
          rx_head_o   <= rx_head_o + PW'(1);
          rx_stored_o <= 1'b1;
        end
        default: st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/can_dma_mailbox.sv
// DMA frame mover: TX mailbox fetch FSM plus the RX ring writer.
// Build option: CAN_DMA_RX_TIMESTAMP_EN (RX slot timestamp word).
module can_dma_mailbox
  import can_dma_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int TX_MAILBOXES = 4,
  parameter int RX_SLOTS     = 8,
  parameter int SLOT_STRIDE  = 4,
  parameter logic [ADDR_WIDTH-1:0] TX_BASE = 20'hA0000,
  parameter logic [ADDR_WIDTH-1:0] RX_BASE = 20'hB0000,
  localparam int MW = $clog2(TX_MAILBOXES),
  localparam int PW = $clog2(RX_SLOTS) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_send_i,
  input  logic [MW-1:0]         tx_mbox_i,
  output logic                  tx_reject_o,
  output logic                  tx_done_o,
  output logic                  tx_pending_o,
  input  logic                  tx_busy_i,
  input  logic                  frame_sent_i,
  output logic [FIELDS_W-1:0]   tx_fields_o,
  output logic [63:0]           tx_data_o,
  input  logic                  rx_frame_ready_i,
  input  logic [FIELDS_W-1:0]   rx_fields_i,
  input  logic [63:0]           rx_data_i,
  input  logic [PW-1:0]         rx_tail_i,
  output logic [PW-1:0]         rx_head_o,
  output logic                  rx_stored_o,
  output logic [7:0]            rx_overflow_cnt_o,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  rd_done,
  input  logic                  rd_busy,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic                  wr_en,
  input  logic                  wr_done,
  input  logic                  wr_busy
);

  localparam int WORDS = 64 / DATA_WIDTH;

  tx_state_t                tx_state;
  logic [1:0]               widx;
  logic [63+DATA_WIDTH:0]   shifted;

  // Data words arrive MSB-first, so each one shifts in from the bottom.
  assign shifted      = {tx_data_o, data_rd};
  assign rd_en        = (tx_state == T_RD_SET ||
                         tx_state == T_RD_DAT) && !rd_busy;
  assign tx_pending_o = (tx_state == T_PRESENT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_state    <= T_IDLE;
      tx_reject_o <= 1'b0;
      tx_done_o   <= 1'b0;
      tx_fields_o <= '0;
      tx_data_o   <= '0;
      addr_rd     <= '0;
      widx        <= '0;
    end else begin
      tx_reject_o <= tx_send_i && (tx_state != T_IDLE);
      tx_done_o   <= 1'b0;
      case (tx_state)
        T_IDLE: if (tx_send_i) begin
          tx_state <= T_RD_SET;
          addr_rd  <= TX_BASE + ADDR_WIDTH'(tx_mbox_i) *
                      ADDR_WIDTH'(SLOT_STRIDE);
        end
        T_RD_SET: if (!rd_busy) tx_state <= T_WAIT_SET;
        T_WAIT_SET: if (rd_done) begin
          tx_state    <= T_RD_DAT;
          tx_fields_o <= decode(data_rd[FIELDS_W-1:0]);
          addr_rd     <= addr_rd + ADDR_WIDTH'(1);
          widx        <= '0;
        end
        T_RD_DAT: if (!rd_busy) tx_state <= T_WAIT_DAT;
        T_WAIT_DAT: if (rd_done) begin
          tx_data_o <= shifted[63:0];
          if (widx == 2'(WORDS - 1)) begin
            tx_state <= T_PRESENT;
          end else begin
            tx_state <= T_RD_DAT;
            widx     <= widx + 2'd1;
            addr_rd  <= addr_rd + ADDR_WIDTH'(1);
          end
        end
        T_PRESENT: if (tx_busy_i) tx_state <= T_SENDING;
        T_SENDING: if (frame_sent_i) begin
          tx_state  <= T_IDLE;
          tx_done_o <= 1'b1;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  can_dma_rx_ring #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RX_SLOTS    (RX_SLOTS),
    .SLOT_STRIDE (SLOT_STRIDE),
    .RX_BASE     (RX_BASE)
  ) u_rx (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .rx_frame_ready_i  (rx_frame_ready_i),
    .rx_fields_i       (rx_fields_i),
    .rx_data_i         (rx_data_i),
    .rx_tail_i         (rx_tail_i),
    .rx_head_o         (rx_head_o),
    .rx_stored_o       (rx_stored_o),
    .rx_overflow_cnt_o (rx_overflow_cnt_o),
    .addr_wr           (addr_wr),
    .data_wr           (data_wr),
    .wr_en             (wr_en),
    .wr_done           (wr_done),
    .wr_busy           (wr_busy)
  );

endmodule

// File: tb/tb_can_dma_mailbox.sv
// Directed bench for can_dma_mailbox with a 1-cycle DMA responder.
// Assumes the default build (no RX timestamp word).
module tb_can_dma_mailbox;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tx_send_i;
  logic [1:0]  tx_mbox_i;
  logic        tx_reject_o;
  logic        tx_done_o;
  logic        tx_pending_o;
  logic        tx_busy_i;
  logic        frame_sent_i;
  logic [24:0] tx_fields_o;
  logic [63:0] tx_data_o;
  logic        rx_frame_ready_i;
  logic [24:0] rx_fields_i;
  logic [63:0] rx_data_i;
  logic [3:0]  rx_tail_i;
  logic [3:0]  rx_head_o;
  logic        rx_stored_o;
  logic [7:0]  rx_overflow_cnt_o;
  logic [19:0] addr_rd;
  logic        rd_en;
  logic [31:0] data_rd;
  logic        rd_done;
  logic        rd_busy;
  logic [19:0] addr_wr;
  logic [31:0] data_wr;
  logic        wr_en;
  logic        wr_done;
  logic        wr_busy;

  always #5 clk = ~clk;

  can_dma_mailbox dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .tx_send_i         (tx_send_i),
    .tx_mbox_i         (tx_mbox_i),
    .tx_reject_o       (tx_reject_o),
    .tx_done_o         (tx_done_o),
    .tx_pending_o      (tx_pending_o),
    .tx_busy_i         (tx_busy_i),
    .frame_sent_i      (frame_sent_i),
    .tx_fields_o       (tx_fields_o),
    .tx_data_o         (tx_data_o),
    .rx_frame_ready_i  (rx_frame_ready_i),
    .rx_fields_i       (rx_fields_i),
    .rx_data_i         (rx_data_i),
    .rx_tail_i         (rx_tail_i),
    .rx_head_o         (rx_head_o),
    .rx_stored_o       (rx_stored_o),
    .rx_overflow_cnt_o (rx_overflow_cnt_o),
    .addr_rd           (addr_rd),
    .rd_en             (rd_en),
    .data_rd           (data_rd),
    .rd_done           (rd_done),
    .rd_busy           (rd_busy),
    .addr_wr           (addr_wr),
    .data_wr           (data_wr),
    .wr_en             (wr_en),
    .wr_done           (wr_done),
    .wr_busy           (wr_busy)
  );

  logic [31:0] rmem [int];
  logic [19:0] ra [16];
  logic [19:0] wa [64];
  logic [31:0] wd [64];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          rej_cnt = 0;
  int          st_cnt = 0;
  logic        rpend = 1'b0;
  logic        wpend = 1'b0;
  logic [19:0] raddr = '0;
  int          checks = 0;
  int          passed = 0;

  // DMA responder and pulse monitors; done follows a request by one cycle.
  always @(negedge clk) begin
    rd_done = rpend;
    if (rpend)
      data_rd = rmem.exists(int'(raddr)) ? rmem[int'(raddr)] : 32'h0;
    rpend = rd_en;
    if (rd_en) begin
      raddr = addr_rd;
      if (rd_cnt < 16) ra[rd_cnt] = addr_rd;
      rd_cnt++;
    end
    wr_done = wpend;
    wpend = wr_en;
    if (wr_en) begin
      if (wr_cnt < 64) begin
        wa[wr_cnt] = addr_wr;
        wd[wr_cnt] = data_wr;
      end
      wr_cnt++;
    end
    if (tx_done_o)   done_cnt++;
    if (tx_reject_o) rej_cnt++;
    if (rx_stored_o) st_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [24:0] f,
                            input logic [63:0] d);
    rx_fields_i = f;
    rx_data_i = d;
    rx_frame_ready_i = 1'b1;
    tick(1);
    rx_frame_ready_i = 1'b0;
  endtask

  task automatic wait_stored(input int n);
    for (int i = 0; i < 100 && st_cnt < n; i++) tick(1);
    chk("stored_wait", 64'(st_cnt >= n), 64'd1);
  endtask

  task automatic wait_pending();
    for (int i = 0; i < 100 && !tx_pending_o; i++) tick(1);
    chk("tx_pending", 64'(tx_pending_o), 64'd1);
  endtask

  task automatic finish_tx();
    tx_busy_i = 1'b1;
    tick(1);
    tx_busy_i = 1'b0;
    chk("tx_pend_clr", 64'(tx_pending_o), 64'd0);
    tick(2);
    frame_sent_i = 1'b1;
    tick(1);
    frame_sent_i = 1'b0;
    tick(2);
  endtask

  initial begin
    rst_i = 1'b0;
    tx_send_i = 1'b0;
    tx_mbox_i = '0;
    tx_busy_i = 1'b0;
    frame_sent_i = 1'b0;
    rx_frame_ready_i = 1'b0;
    rx_fields_i = '0;
    rx_data_i = '0;
    rx_tail_i = '0;
    rd_busy = 1'b0;
    wr_busy = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    data_rd = '0;
    rmem[32'hA0008] = 32'h01F5_8229;
    rmem[32'hA0009] = 32'h1122_3344;
    rmem[32'hA000A] = 32'h5566_7788;
    rmem[32'hA0004] = 32'h0000_0045;
    rmem[32'hA0005] = 32'h0102_0304;
    rmem[32'hA0006] = 32'h0506_0708;
    tick(3);
    chk("rst_pending", 64'(tx_pending_o), 64'd0);
    chk("rst_reject", 64'(tx_reject_o), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_head", 64'(rx_head_o), 64'd0);
    chk("rst_ovf", 64'(rx_overflow_cnt_o), 64'd0);
    rst_i = 1'b1;
    tick(1);

    tx_mbox_i = 2'd2;
    tx_send_i = 1'b1;
    tick(1);
    tx_send_i = 1'b0;
    wait_pending();
    chk("rd_count", 64'(rd_cnt), 64'd3);
    chk("rd_addr0", 64'(ra[0]), 64'hA0008);
    chk("rd_addr1", 64'(ra[1]), 64'hA0009);
    chk("rd_addr2", 64'(ra[2]), 64'hA000A);
    chk("tx_fields", 64'(tx_fields_o), 64'h01F5_8229);
    chk("tx_data", tx_data_o, 64'h1122_3344_5566_7788);
    finish_tx();
    chk("tx_done1", 64'(done_cnt), 64'd1);

    tx_mbox_i = 2'd1;
    tx_send_i = 1'b1;
    tick(1);
    tx_send_i = 1'b0;
    for (int i = 0; i < 30 && rd_cnt < 5; i++) tick(1);
    tick(1);
    tx_mbox_i = 2'd3;
    tx_send_i = 1'b1;
    tick(1);
    tx_send_i = 1'b0;
    wait_pending();
    chk("reject_cnt", 64'(rej_cnt), 64'd1);
    chk("rd_count2", 64'(rd_cnt), 64'd6);
    chk("rd_addr3", 64'(ra[3]), 64'hA0004);
    chk("tx_fields2", 64'(tx_fields_o), 64'h45);
    chk("tx_data2", tx_data_o, 64'h0102_0304_0506_0708);
    finish_tx();
    chk("tx_done2", 64'(done_cnt), 64'd2);

    send_frame(25'h129, 64'hDEADBEEF_CAFEF00D);
    wait_stored(1);
    chk("wr_count1", 64'(wr_cnt), 64'd3);
    chk("wr_addr0", 64'(wa[0]), 64'hB0001);
    chk("wr_data0", 64'(wd[0]), 64'hDEADBEEF);
    chk("wr_addr1", 64'(wa[1]), 64'hB0002);
    chk("wr_data1", 64'(wd[1]), 64'hCAFEF00D);
    chk("wr_addr2", 64'(wa[2]), 64'hB0000);
    chk("wr_data2", 64'(wd[2]), 64'h8000_0129);
    chk("head1", 64'(rx_head_o), 64'd1);

    for (int f = 1; f < 8; f++) begin
      send_frame(25'(f), {32'(f), 32'hFFFF_0000});
      wait_stored(f + 1);
    end
    chk("head_full", 64'(rx_head_o), 64'd8);
    chk("wr_count8", 64'(wr_cnt), 64'd24);
    chk("slot7_addr", 64'(wa[23]), 64'hB001C);
    send_frame(25'h1FF, 64'h0);
    tick(20);
    chk("ovf_full", 64'(rx_overflow_cnt_o), 64'd1);
    chk("wr_count_drop", 64'(wr_cnt), 64'd24);
    chk("head_drop", 64'(rx_head_o), 64'd8);
    rx_tail_i = 4'd1;
    tick(2);
    send_frame(25'h0AB, 64'h0A0B0C0D_0E0F1011);
    wait_stored(9);
    chk("wrap_addr0", 64'(wa[24]), 64'hB0001);
    chk("wrap_data0", 64'(wd[24]), 64'h0A0B0C0D);
    chk("wrap_addr2", 64'(wa[26]), 64'hB0000);
    chk("wrap_set", 64'(wd[26]), 64'hC000_00AB);
    chk("head9", 64'(rx_head_o), 64'd9);

    rx_tail_i = 4'd5;
    tick(2);
    send_frame(25'h011, 64'h1111_1111_2222_2222);
    tick(2);
    send_frame(25'h022, 64'h3333_3333_4444_4444);
    chk("ovf_skid", 64'(rx_overflow_cnt_o), 64'd1);
    tick(1);
    send_frame(25'h033, 64'h5555_5555_6666_6666);
    chk("ovf_third", 64'(rx_overflow_cnt_o), 64'd2);
    wait_stored(11);
    tick(20);
    chk("head11", 64'(rx_head_o), 64'd11);
    chk("wr_count_burst", 64'(wr_cnt), 64'd33);
    chk("stored_burst", 64'(st_cnt), 64'd11);
    chk("a_set", 64'(wd[29]), 64'hC000_0011);
    chk("b_addr0", 64'(wa[30]), 64'hB0009);
    chk("b_data1", 64'(wd[31]), 64'h4444_4444);
    chk("b_addr2", 64'(wa[32]), 64'hB0008);
    chk("b_set", 64'(wd[32]), 64'hC000_0022);

    send_frame(25'h044, 64'h7777_7777_8888_8888);
    for (int i = 0; i < 30 && wr_cnt < 34; i++) tick(1);
    rst_i = 1'b0;
    tick(2);
    chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
    chk("rst_mid_head", 64'(rx_head_o), 64'd0);
    chk("rst_mid_ovf", 64'(rx_overflow_cnt_o), 64'd0);
    rst_i = 1'b1;
    tick(10);
    chk("rst_mid_wr_cnt", 64'(wr_cnt), 64'd34);
    chk("rst_mid_stored", 64'(st_cnt), 64'd11);
    chk("rst_mid_head2", 64'(rx_head_o), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
